spi_dac_wr: RTL and testbench

SPI write engine for the dual-channel 12-bit DAC. It sits directly downstream of the two-channel sequencing FSM. On each single-cycle `strw_i` pulse it latches one channel's sample, builds a 16-bit DAC command word and shifts it out MSB-first in SPI mode 0. It then returns a one-cycle `eow_i`-compatible end-of-word pulse that advances the sequencer.

---
 rtl/spi_dac_wr_if.sv | 27 ++
 rtl/spi_dac_wr.sv | 120 ++++++++++++
 tb/tb_spi_dac_wr.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/spi_dac_wr_if.sv
// Bus between the channel sequencer and the DAC SPI write engine:
// start/select/sample inputs on one side, SPI pins and status on the other.
interface spi_dac_wr_if #(
    parameter int DATA_W = 12
);
    logic              strw_i;
    logic              selch_i;
    logic [DATA_W-1:0] data0_i;
    logic [DATA_W-1:0] data1_i;
    logic              sclk_o;
    logic              mosi_o;
    logic              cs_no;
    logic              busy_o;
    logic              eow_o;

    // Write engine side
    modport slave (
        input  strw_i, selch_i, data0_i, data1_i,
        output sclk_o, mosi_o, cs_no, busy_o, eow_o
    );

    // Sequencer side
    modport master (
        output strw_i, selch_i, data0_i, data1_i,
        input  sclk_o, mosi_o, cs_no, busy_o, eow_o
    );
endinterface

// File: rtl/spi_dac_wr.sv
// SPI mode-0 write engine for the dual-channel 12-bit DAC. A strobe in IDLE
// captures a 16-bit command word {ch, unbuffered, 1x gain, active, sample},
// which is shifted out MSB first; a one-cycle end-of-word pulse closes the
// frame in the last cycle of the CS-high gap.
module spi_dac_wr #(
    parameter int CLK_DIV = 4,
    parameter int DATA_W  = 12
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    spi_dac_wr_if.slave bus
);
    localparam int         FRAME_W = 16;
    localparam logic [7:0] RELOAD  = 8'(CLK_DIV - 1);

    typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, GAP} state_t;

    state_t               state, state_next;
    logic [7:0]           cnt, cnt_next;
    logic [3:0]           bits, bits_next;
    logic [FRAME_W-1:0]   shreg, shreg_next;
    logic [DATA_W-1:0]    sample;
    logic                 active_next;

    assign sample = bus.selch_i ? bus.data1_i : bus.data0_i;

    // State, half-period counter, bit counter and shift register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= IDLE;
            cnt   <= '0;
            bits  <= '0;
            shreg <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            bits  <= bits_next;
            shreg <= shreg_next;
        end
    end

    // Next-state logic; the bit counter starts at 0 and wraps on the first
    // HIGH->LOW, so reaching 0 again after a HIGH marks the 16th bit
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        bits_next  = bits;
        shreg_next = shreg;
        case (state)
            IDLE: begin
                if (bus.strw_i) begin
                    state_next = SETUP;
                    cnt_next   = RELOAD;
                    bits_next  = '0;
                    shreg_next = {bus.selch_i, 1'b0, 1'b1, 1'b1, sample};
                end
            end
            SETUP: begin
                if (cnt == 8'd0) begin
                    state_next = HIGH;
                    cnt_next   = RELOAD;
                end else begin
                    cnt_next = cnt - 8'd1;
                end
            end
            HIGH: begin
                if (cnt == 8'd0) begin
                    state_next = LOW;
                    cnt_next   = RELOAD;
                    bits_next  = bits - 4'd1;
                    shreg_next = {shreg[FRAME_W-2:0], 1'b0};
                end else begin
                    cnt_next = cnt - 8'd1;
                end
            end
            LOW: begin
                if (cnt == 8'd0) begin
                    state_next = (bits != 4'd0) ? HIGH : GAP;
                    cnt_next   = RELOAD;
                end else begin
                    cnt_next = cnt - 8'd1;
                end
            end
            GAP: begin
                if (cnt == 8'd0) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt - 8'd1;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
                bits_next  = '0;
            end
        endcase
    end

    assign active_next = (state_next == SETUP) || (state_next == HIGH) ||
                         (state_next == LOW);

    // Outputs registered from the next state so they align with the state
    // register; after 16 shifts the register holds zeros, so MOSI idles low
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            bus.cs_no  <= 1'b1;
            bus.sclk_o <= 1'b0;
            bus.mosi_o <= 1'b0;
            bus.busy_o <= 1'b0;
            bus.eow_o  <= 1'b0;
        end else begin
            bus.cs_no  <= !active_next;
            bus.sclk_o <= (state_next == HIGH);
            bus.mosi_o <= active_next && shreg_next[FRAME_W-1];
            bus.busy_o <= (state_next != IDLE);
            bus.eow_o  <= (state_next == GAP) && (cnt_next == 8'd0);
        end
    end
endmodule

// File: tb/tb_spi_dac_wr.sv
// Directed bench for spi_dac_wr: a CLK_DIV=4 instance and a CLK_DIV=1
// instance, with a per-cycle SPI monitor and hand-computed expected frames.
module tb_spi_dac_wr;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    spi_dac_wr_if #(.DATA_W(12)) bus4 ();
    spi_dac_wr_if #(.DATA_W(12)) bus1 ();

    spi_dac_wr #(.CLK_DIV(4), .DATA_W(12)) dut4 (.clk_i(clk), .rst_ni(rst_n), .bus(bus4.slave));
    spi_dac_wr #(.CLK_DIV(1), .DATA_W(12)) dut1 (.clk_i(clk), .rst_ni(rst_n), .bus(bus1.slave));

    int n_checks = 0;
    int n_errors = 0;

    // Monitor state
    int          rises4 = 0, eow4 = 0, busy4 = 0, bad4 = 0, eow_cyc4 = 0;
    int          cs_run4 = 0, cs_gap4 = 0, nfr4 = 0;
    logic [15:0] cap4 = '0;
    logic [15:0] frm4 [0:7];
    logic        sclk4_q = 1'b0, mosi4_q = 1'b0;
    int          rises1 = 0, eow1 = 0, busy1 = 0, badper1 = 0, eow_cyc1 = 0, last_rise1 = 0;
    logic [15:0] cap1 = '0;
    logic        sclk1_q = 1'b0;
    int          strw_cyc4 = 0, strw_cyc1 = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Sample DUT outputs 1 time unit after each rising edge
    always begin
        @(posedge clk);
        #1;
        if (bus4.sclk_o && !sclk4_q) begin
            rises4++;
            cap4 = {cap4[14:0], bus4.mosi_o};
            if (bus4.cs_no) bad4++;
        end
        if (bus4.sclk_o && sclk4_q && (bus4.mosi_o != mosi4_q)) bad4++;
        if (bus4.busy_o) busy4++;
        if (bus4.eow_o) begin
            eow4++;
            eow_cyc4 = cyc;
            if (nfr4 < 8) frm4[nfr4] = cap4;
            nfr4++;
        end
        if (bus4.cs_no) cs_run4++;
        else begin
            if (cs_run4 != 0) cs_gap4 = cs_run4;
            cs_run4 = 0;
        end
        sclk4_q = bus4.sclk_o;
        mosi4_q = bus4.mosi_o;

        if (bus1.sclk_o && !sclk1_q) begin
            if (rises1 != 0 && (cyc - last_rise1) != 2) badper1++;
            last_rise1 = cyc;
            rises1++;
            cap1 = {cap1[14:0], bus1.mosi_o};
        end
        if (bus1.busy_o) busy1++;
        if (bus1.eow_o) begin
            eow1++;
            eow_cyc1 = cyc;
        end
        sclk1_q = bus1.sclk_o;
    end

    // Stimulus point: 2 time units after the rising edge
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic clear4();
        rises4 = 0; eow4 = 0; busy4 = 0; bad4 = 0; nfr4 = 0;
    endtask

    task automatic strobe4(input logic sel, input logic [11:0] d0, input logic [11:0] d1);
        bus4.selch_i = sel;
        bus4.data0_i = d0;
        bus4.data1_i = d1;
        bus4.strw_i  = 1'b1;
        strw_cyc4    = cyc;
        tick();
        bus4.strw_i  = 1'b0;
    endtask

    task automatic wait_eow4(input int target, input int limit);
        int n = 0;
        while (eow4 < target && n < limit) begin
            tick();
            n++;
        end
        check("eow4_seen", 32'(eow4 >= target), 32'd1);
    endtask

    initial begin
        bus4.strw_i = 1'b0; bus4.selch_i = 1'b0; bus4.data0_i = '0; bus4.data1_i = '0;
        bus1.strw_i = 1'b0; bus1.selch_i = 1'b0; bus1.data0_i = '0; bus1.data1_i = '0;

        // Reset held, then released between edges
        repeat (3) tick();
        check("rst_cs", 32'(bus4.cs_no), 32'd1);
        check("rst_busy", 32'(bus4.busy_o), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) tick();
        check("idle_cs", 32'(bus4.cs_no), 32'd1);
        check("idle_sclk", 32'(bus4.sclk_o), 32'd0);
        check("idle_mosi", 32'(bus4.mosi_o), 32'd0);
        check("idle_busy", 32'(bus4.busy_o), 32'd0);
        check("idle_eow", 32'(bus4.eow_o), 32'd0);
        check("idle_cs1", 32'(bus1.cs_no), 32'd1);
        check("idle_sclk_edges", 32'(rises4 + rises1), 32'd0);

        // Channel A frame
        clear4();
        strobe4(1'b0, 12'hABC, 12'h555);
        check("a_busy_start", 32'(bus4.busy_o), 32'd1);
        check("a_cs_start", 32'(bus4.cs_no), 32'd0);
        wait_eow4(1, 400);
        check("a_latency", 32'(eow_cyc4 - strw_cyc4), 32'd136);
        tick();
        check("a_frame", 32'(frm4[0]), 32'h3ABC);
        check("a_rises", 32'(rises4), 32'd16);
        check("a_busy_cycles", 32'(busy4), 32'd136);
        check("a_mosi_stable", 32'(bad4), 32'd0);
        check("a_busy_end", 32'(bus4.busy_o), 32'd0);
        repeat (5) tick();

        // Channel B frame; data0 differs to show it is ignored
        clear4();
        strobe4(1'b1, 12'hFFF, 12'h123);
        wait_eow4(1, 400);
        tick();
        check("b_frame", 32'(frm4[0]), 32'hB123);
        check("b_rises", 32'(rises4), 32'd16);
        repeat (5) tick();

        // Sequencer pair: next strobe in the first cycle after eow
        clear4();
        strobe4(1'b0, 12'hFFF, 12'h000);
        wait_eow4(1, 400);
        tick();
        strobe4(1'b1, 12'hFFF, 12'h000);
        wait_eow4(2, 400);
        check("seq_latency2", 32'(eow_cyc4 - strw_cyc4), 32'd136);
        tick();
        check("seq_frame0", 32'(frm4[0]), 32'h3FFF);
        check("seq_frame1", 32'(frm4[1]), 32'hB000);
        check("seq_cs_gap_ge5", 32'(cs_gap4 >= 5), 32'd1);
        check("seq_eows", 32'(eow4), 32'd2);
        check("seq_rises", 32'(rises4), 32'd32);
        repeat (5) tick();

        // Strobe and data change while busy
        clear4();
        strobe4(1'b0, 12'h5A5, 12'h000);
        repeat (39) tick();
        bus4.data0_i = 12'h000;
        strobe4(1'b1, 12'h000, 12'hFFF);
        bus4.data0_i = 12'h777;
        wait_eow4(1, 400);
        repeat (300) tick();
        check("busy_frame", 32'(frm4[0]), 32'h35A5);
        check("busy_eows", 32'(eow4), 32'd1);
        check("busy_rises", 32'(rises4), 32'd16);

        // Reset at bit 7 aborts at once
        clear4();
        strobe4(1'b0, 12'hC3C, 12'h000);
        begin
            int n = 0;
            while (rises4 < 7 && n < 400) begin
                tick();
                n++;
            end
        end
        check("abort_reached_bit7", 32'(rises4), 32'd7);
        rst_n = 1'b0;
        #1;
        check("abort_cs", 32'(bus4.cs_no), 32'd1);
        check("abort_busy", 32'(bus4.busy_o), 32'd0);
        check("abort_sclk", 32'(bus4.sclk_o), 32'd0);
        repeat (3) tick();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (200) tick();
        check("abort_no_eow", 32'(eow4), 32'd0);
        check("abort_idle_busy", 32'(bus4.busy_o), 32'd0);
        clear4();
        strobe4(1'b0, 12'hC3C, 12'h000);
        wait_eow4(1, 400);
        tick();
        check("abort_next_frame", 32'(frm4[0]), 32'h3C3C);
        check("abort_next_rises", 32'(rises4), 32'd16);

        // CLK_DIV=1 instance
        rises1 = 0; eow1 = 0; busy1 = 0; badper1 = 0;
        bus1.selch_i = 1'b0;
        bus1.data0_i = 12'h555;
        bus1.data1_i = 12'hAAA;
        bus1.strw_i  = 1'b1;
        strw_cyc1    = cyc;
        tick();
        bus1.strw_i  = 1'b0;
        begin
            int n = 0;
            while (eow1 < 1 && n < 200) begin
                tick();
                n++;
            end
        end
        check("d1_eow_seen", 32'(eow1), 32'd1);
        check("d1_latency", 32'(eow_cyc1 - strw_cyc1), 32'd34);
        check("d1_frame", 32'(cap1), 32'h3555);
        check("d1_rises", 32'(rises1), 32'd16);
        check("d1_period", 32'(badper1), 32'd0);
        check("d1_busy_cycles", 32'(busy1), 32'd34);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
